muldiv_unit: RTL and testbench

Iterative multiply/divide unit implementing the RV32M operations alongside the single-cycle combinational `alu`. It is parametrised in operand width and uses a start/busy/done handshake. The execute stage issues one operation and stalls on `busy`, then captures `Y` on the `done` pulse. Results are radix-2 (one bit per cycle) and bit-exact to the RISC-V M extension, including its divide-by-zero and overflow rules.

---
 rtl/muldiv_pkg.sv | 33 +++
 rtl/muldiv_step.sv | 34 +++
 rtl/muldiv_unit.sv | 137 +++++++++++++
 tb/tb_muldiv_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 op encodings, FSM state type and operand-signedness helpers.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_t;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // MUL's low half is sign-agnostic, so it is handled as unsigned.
  function automatic logic signed_a(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic signed_b(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply (acc = {hi, multiplier}),
// restoring trial-subtract for divide (acc = {remainder, dividend/quotient}).
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 div,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     m,
  output logic [2*WIDTH-1:0]   acc_next
);

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  always_comb begin
    addend   = acc[0] ? m : {WIDTH{1'b0}};
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff     = {1'b0, shifted} - {2'b00, m};
    acc_next = {sum, acc[WIDTH-1:1]};
    // A borrow out of diff means the trial subtract failed: keep the shifted remainder.
    if (div) begin
      if (diff[WIDTH+1])
        acc_next = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else
        acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with start/busy/done handshake.
// Optional MULDIV_EARLY_EN lets trivial cases skip the iteration phase.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Y,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t               state, state_next;
  logic                 accept, early;
  logic [2:0]           op_r;
  logic [WIDTH-1:0]     a_r, m;
  logic [2*WIDTH-1:0]   acc, acc_next;
  logic [CW-1:0]        cnt;
  logic                 neg_a, neg_b, divz, ovf, mulz, div_r, rem_op;
  logic                 sa_in, sb_in, divz_in, ovf_in, mulz_in;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     quo, rem, res;

  assign sa_in   = signed_a(op) & a[WIDTH-1];
  assign sb_in   = signed_b(op) & b[WIDTH-1];
  assign mag_a   = sa_in ? -a : a;
  assign mag_b   = sb_in ? -b : b;
  assign divz_in = is_div(op) && (b == '0);
  assign ovf_in  = ((op == OP_DIV) || (op == OP_REM)) && (a == MIN_NEG) && (b == '1);
  assign mulz_in = !is_div(op) && ((a == '0) || (b == '0));

`ifdef MULDIV_EARLY_EN
  assign early = divz_in | ovf_in | mulz_in;
`else
  assign early = 1'b0;
`endif

  assign busy   = (state != S_IDLE);
  assign div_r  = is_div(op_r);
  assign rem_op = (op_r == OP_REM) || (op_r == OP_REMU);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        accept     = 1'b1;
        state_next = early ? S_FIX : S_CALC;
      end
      S_CALC:  if (cnt == LAST) state_next = S_FIX;
      S_FIX:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div      (div_r),
    .acc      (acc),
    .m        (m),
    .acc_next (acc_next)
  );

  // Special cases override the iterated result so both builds agree bit for bit.
  always_comb begin
    prod = (neg_a ^ neg_b) ? -acc : acc;
    quo  = (neg_a ^ neg_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem  = neg_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    case (op_r)
      OP_MUL:                       res = prod[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res = prod[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:              res = quo;
      OP_REM, OP_REMU:              res = rem;
      default:                      res = rem;
    endcase
    if (divz)      res = rem_op ? a_r : {WIDTH{1'b1}};
    else if (ovf)  res = rem_op ? {WIDTH{1'b0}} : a_r;
    else if (mulz) res = {WIDTH{1'b0}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r  <= '0;
      a_r   <= '0;
      m     <= '0;
      acc   <= '0;
      cnt   <= '0;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
      divz  <= 1'b0;
      ovf   <= 1'b0;
      mulz  <= 1'b0;
      Y     <= '0;
      zero  <= 1'b1;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        op_r  <= op;
        a_r   <= a;
        neg_a <= sa_in;
        neg_b <= sb_in;
        divz  <= divz_in;
        ovf   <= ovf_in;
        mulz  <= mulz_in;
        m     <= is_div(op) ? mag_b : mag_a;
        acc   <= is_div(op) ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
        cnt   <= '0;
      end else if (state == S_CALC) begin
        acc <= acc_next;
        cnt <= cnt + CW'(1);
      end
      if (state == S_FIX) begin
        Y    <= res;
        zero <= (res == '0);
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M vectors, latency,
// back-to-back issue, ignored start and mid-operation reset.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int WIDTH    = 32;
  localparam int PERIOD   = 10;
  localparam int CALC_LAT = WIDTH + 2;
`ifdef MULDIV_EARLY_EN
  localparam int EARLY_LAT = 2;
`else
  localparam int EARLY_LAT = CALC_LAT;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [2:0]       op = '0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy, done, zero;
  logic [WIDTH-1:0] Y;

  typedef struct {
    logic [WIDTH-1:0] y;
    logic             z;
    int               lat;
    longint           t;
  } exp_t;

  typedef struct {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] y;
    logic             z;
    bit               early;
  } vec_t;

  exp_t  expq[$];
  string nameq[$];
  int    checks = 0;
  int    fails  = 0;
  exp_t  mon_e;
  string mon_n;

  localparam int NV = 24;
  vec_t vecs [NV] = '{
    '{OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 1'b0},
    '{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0},
    '{OP_MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 1'b0, 1'b0},
    '{OP_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0, 1'b0},
    '{OP_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0, 1'b0},
    '{OP_DIVU,   32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC, 1'b0, 1'b0},
    '{OP_REMU,   32'h00000007, 32'h00000007, 32'h00000000, 1'b1, 1'b0},
    '{OP_DIV,    32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b1},
    '{OP_REM,    32'h00000005, 32'h00000000, 32'h00000005, 1'b0, 1'b1},
    '{OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b1},
    '{OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b1},
    '{OP_DIVU,   32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b1},
    '{OP_REMU,   32'h00000005, 32'h00000000, 32'h00000005, 1'b0, 1'b1},
    '{OP_DIV,    32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b1},
    '{OP_MUL,    32'h00000000, 32'h00012345, 32'h00000000, 1'b1, 1'b1},
    '{OP_MUL,    32'hFFFFFFFD, 32'h00000006, 32'hFFFFFFEE, 1'b0, 1'b0},
    '{OP_MULH,   32'hFFFFFFFD, 32'h00000006, 32'hFFFFFFFF, 1'b0, 1'b0},
    '{OP_DIV,    32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 1'b0},
    '{OP_REM,    32'h00000007, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0},
    '{OP_REM,    32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0, 1'b0},
    '{OP_DIV,    32'hFFFFFFF9, 32'hFFFFFFFE, 32'h00000003, 1'b0, 1'b0},
    '{OP_MULHU,  32'h80000000, 32'h00000002, 32'h00000001, 1'b0, 1'b0},
    '{OP_MULH,   32'h80000000, 32'h00000002, 32'hFFFFFFFF, 1'b0, 1'b0},
    '{OP_MUL,    32'h12345678, 32'h00000010, 32'h23456780, 1'b0, 1'b0}
  };

  muldiv_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .Y     (Y),
    .zero  (zero)
  );

  always #(PERIOD/2) clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, act, expv);
    end
  endtask

  // Called on a falling edge; drives one request and returns one cycle later with start low.
  task automatic applyStimulus(input logic [2:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                               input logic [WIDTH-1:0] ey, input logic ez, input bit early,
                               input bit track, input string name);
    int   n;
    exp_t e;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checkOutput({name, "_idle_timeout"}, 64'd1, 64'd0);
      return;
    end
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    if (track) begin
      e.y   = ey;
      e.z   = ez;
      e.lat = early ? EARLY_LAT : CALC_LAT;
      e.t   = longint'($time);
      expq.push_back(e);
      nameq.push_back(name);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (expq.size() == 0) begin
        checkOutput("unexpected_done", 64'd1, 64'd0);
      end else begin
        mon_e = expq.pop_front();
        mon_n = nameq.pop_front();
        checkOutput({mon_n, "_Y"}, 64'(Y), 64'(mon_e.y));
        checkOutput({mon_n, "_zero"}, 64'(zero), 64'(mon_e.z));
        checkOutput({mon_n, "_latency"}, 64'((longint'($time) - mon_e.t) / PERIOD), 64'(mon_e.lat));
      end
    end
  end

  initial begin
    int n;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_Y",    64'(Y),    64'd0);
    checkOutput("reset_zero", 64'(zero), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(OP_MUL, 32'd3, 32'd6, 32'd18, 1'b0, 1'b0, 1'b1, "mul_3x6");
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    checkOutput("mul_busy_cycles", 64'(n), 64'(WIDTH + 1));

    for (int i = 0; i < NV; i++)
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].y, vecs[i].z, vecs[i].early,
                    1'b1, $sformatf("vec%0d", i));

    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("b2b_done_seen", 64'(done), 64'd1);
    applyStimulus(OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 1'b1, "b2b_divu");
    checkOutput("b2b_accepted", 64'(busy), 64'd1);

    applyStimulus(OP_MUL, 32'd3, 32'd6, 32'd18, 1'b0, 1'b0, 1'b1, "ignored_start_mul");
    for (int k = 0; k < 5; k++) begin
      start = 1'b1;
      op    = OP_DIV;
      a     = 32'd100;
      b     = 32'd7;
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput("ignored_start_busy", 64'(busy), 64'd1);

    applyStimulus(OP_DIV, 32'd1000, 32'd7, 32'd0, 1'b0, 1'b0, 1'b0, "rst_div");
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midop_reset_busy", 64'(busy), 64'd0);
    checkOutput("midop_reset_done", 64'(done), 64'd0);
    checkOutput("midop_reset_Y",    64'(Y),    64'd0);
    checkOutput("midop_reset_zero", 64'(zero), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    applyStimulus(OP_MUL, 32'd3, 32'd6, 32'd18, 1'b0, 1'b0, 1'b1, "post_reset_mul");

    n = 0;
    while (expq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (expq.size() != 0)
      checkOutput("drain_timeout", 64'(expq.size()), 64'd0);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
